// File: rtl/ascii_parse_pkg.sv
// Shared types and ASCII constants for the streaming ASCII number parser.
package ascii_parse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_BASE = 2'd1,
    ERR_CHAR = 2'd2,
    ERR_OVF  = 2'd3
  } err_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII digit decoder; lowercase hex is accepted only when
// PARSE_LOWERCASE_EN is defined.
module ascii_digit_decode
  import ascii_parse_pkg::*;
(
  input  logic [7:0] ch,
  input  logic [4:0] base,
  output logic [3:0] digit,
  output logic       is_valid
);

  logic known;

  always_comb begin
    digit = 4'd0;
    known = 1'b0;
    if (ch >= ASCII_0 && ch <= ASCII_0 + 8'd9) begin
      digit = 4'(ch - ASCII_0);
      known = 1'b1;
    end else if (ch >= ASCII_UA && ch <= ASCII_UA + 8'd5) begin
      digit = 4'(ch - ASCII_UA + 8'd10);
      known = 1'b1;
    end
`ifdef PARSE_LOWERCASE_EN
    else if (ch >= ASCII_LA && ch <= ASCII_LA + 8'd5) begin
      digit = 4'(ch - ASCII_LA + 8'd10);
      known = 1'b1;
    end
`endif
    // A digit is only meaningful when it fits the active base.
    is_valid = known && ({1'b0, digit} < base);
  end

endmodule

// File: rtl/ascii_base_parser.sv
// Streaming ASCII-to-binary parser for runtime bases 2..16 (MSD first).
// Optional lowercase hex digits via PARSE_LOWERCASE_EN.
module ascii_base_parser
  import ascii_parse_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       base,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic [7:0]       char_data,
  input  logic             char_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [1:0]       out_err,
  output logic             busy
);

  state_t             state_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [4:0]         base_reg;
  err_t               err_reg;

  logic [3:0]         digit;
  logic               dig_valid;
  logic [WIDTH+3:0]   t;
  logic [WIDTH-1:0]   acc_next;
  err_t               err_next;
  logic               accept;

  ascii_digit_decode u_decode (
    .ch       (char_data),
    .base     (base_reg),
    .digit    (digit),
    .is_valid (dig_valid)
  );

  assign accept = char_valid && char_ready;

  // Four guard bits hold acc*16+15 exactly, so any nonzero guard bit means overflow.
  always_comb begin
    t        = ({4'b0000, acc_reg} * {{(WIDTH-1){1'b0}}, base_reg})
             + {{WIDTH{1'b0}}, digit};
    acc_next = acc_reg;
    err_next = err_reg;
    if (err_reg == ERR_OK) begin
      if (!dig_valid)
        err_next = ERR_CHAR;
      else if (t[WIDTH+3:WIDTH] != 4'd0)
        err_next = ERR_OVF;
      else
        acc_next = t[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      base_reg   <= 5'd0;
      err_reg    <= ERR_OK;
      char_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_err    <= 2'd0;
      busy       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg <= '0;
            busy    <= 1'b1;
            if (base >= 5'd2 && base <= 5'd16) begin
              base_reg   <= base;
              err_reg    <= ERR_OK;
              char_ready <= 1'b1;
              state_reg  <= ACCUM;
            end else begin
              err_reg   <= ERR_BASE;
              out_valid <= 1'b1;
              out_value <= '0;
              out_err   <= ERR_BASE;
              state_reg <= DONE;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_reg <= acc_next;
            err_reg <= err_next;
            if (char_last) begin
              char_ready <= 1'b0;
              out_valid  <= 1'b1;
              out_value  <= (err_next == ERR_OK) ? acc_next : '0;
              out_err    <= err_next;
              state_reg  <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_base_parser.sv
// Self-checking bench for ascii_base_parser: directed strings against a
// high-level value model, plus a per-cycle output compare process.
module tb_ascii_base_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  base;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_data;
  logic        char_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic [1:0]  out_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic        exp_active = 1'b0;
  logic [31:0] exp_value  = 32'd0;
  logic [1:0]  exp_err    = 2'd0;

  always #5 clk = ~clk;

  ascii_base_parser #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base       (base),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_data  (char_data),
    .char_last  (char_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_err    (out_err),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Value model: plain integer arithmetic on the string, no notion of FSM.
  task automatic model(input logic [4:0] b, input string s,
                       output logic [31:0] v, output logic [1:0] e);
    longint unsigned acc;
    int bi, ci, d;
    acc = 0;
    e   = 2'd0;
    bi  = int'(b);
    if (bi < 2 || bi > 16) begin
      v = 32'd0;
      e = 2'd1;
      return;
    end
    for (int i = 0; i < s.len(); i++) begin
      ci = int'(s[i]);
      if (ci >= 48 && ci <= 57)       d = ci - 48;
      else if (ci >= 65 && ci <= 70)  d = ci - 55;
`ifdef PARSE_LOWERCASE_EN
      else if (ci >= 97 && ci <= 102) d = ci - 87;
`endif
      else                            d = -1;
      if (d >= bi) d = -1;
      if (e == 2'd0) begin
        if (d < 0) e = 2'd2;
        else begin
          acc = acc * longint'(bi) + longint'(d);
          if (acc > 64'hFFFF_FFFF) e = 2'd3;
        end
      end
    end
    v = (e == 2'd0) ? acc[31:0] : 32'd0;
  endtask

  // Whenever a result is presented it must match the pending expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_active) chk("cmp_unexpected_valid", 32'd1, 32'd0);
      else begin
        chk("cmp_value", out_value, exp_value);
        chk("cmp_err", {30'd0, out_err}, {30'd0, exp_err});
      end
    end
  end

  task automatic run_str(input logic [4:0] b, input string s,
                         input logic [31:0] lit_v, input logic [1:0] lit_e, input int hold);
    logic [31:0] mv;
    logic [1:0]  me;
    model(b, s, mv, me);
    chk("model_value", mv, lit_v);
    chk("model_err", {30'd0, me}, {30'd0, lit_e});
    exp_value  = mv;
    exp_err    = me;
    exp_active = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    base  = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (b >= 5'd2 && b <= 5'd16) begin
      for (int i = 0; i < s.len(); i++) begin
        char_valid = 1'b1;
        char_data  = s[i];
        char_last  = (i == s.len() - 1);
        @(negedge clk);
        chk("char_ready_accum", {31'd0, char_ready}, 32'd1);
        @(posedge clk); #1;
      end
      char_valid = 1'b0;
      char_last  = 1'b0;
    end else begin
      char_valid = 1'b1;
      char_data  = 8'h31;
    end
    @(negedge clk);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    chk("char_ready_done", {31'd0, char_ready}, 32'd0);
    chk("busy_done", {31'd0, busy}, 32'd1);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      start = 1'b1;
      base  = 5'd10;
    end
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    out_ready  = 1'b0;
    start      = 1'b0;
    char_valid = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    $display("TXN base=%0d str=\"%s\" value=%0h err=%0d", b, s, mv, me);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_value"}, out_value, 32'd0);
    chk({tag, "_out_err"}, {30'd0, out_err}, 32'd0);
    chk({tag, "_char_ready"}, {31'd0, char_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base = 5'd0;
    char_valid = 1'b0; char_data = 8'd0; char_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_str(5'd16, "1A3",        32'h0000_01A3, 2'd0, 0);
    run_str(5'd2,  "101",        32'd5,         2'd0, 0);
    run_str(5'd10, "4294967295", 32'hFFFF_FFFF, 2'd0, 0);
    run_str(5'd10, "4294967296", 32'd0,         2'd3, 0);
    run_str(5'd16, "FFFFFFFF",   32'hFFFF_FFFF, 2'd0, 0);
    run_str(5'd16, "100000000",  32'd0,         2'd3, 0);
    run_str(5'd1,  "",           32'd0,         2'd1, 0);
    run_str(5'd0,  "",           32'd0,         2'd1, 0);
    run_str(5'd8,  "19",         32'd0,         2'd2, 0);
    run_str(5'd10, "1-2",        32'd0,         2'd2, 0);
`ifdef PARSE_LOWERCASE_EN
    run_str(5'd16, "ff",         32'd255,       2'd0, 0);
`else
    run_str(5'd16, "ff",         32'd0,         2'd2, 0);
`endif
    run_str(5'd10, "9999999999X", 32'd0,        2'd3, 0);
    run_str(5'd16, "G",          32'd0,         2'd2, 0);
    run_str(5'd3,  "0",          32'd0,         2'd0, 0);
    run_str(5'd10, "0007",       32'd7,         2'd0, 0);
    run_str(5'd10, "77",         32'd77,        2'd0, 5);

    // Abandon a string mid-stream with reset.
    @(posedge clk); #1;
    start = 1'b1; base = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    char_valid = 1'b1; char_data = 8'h31; char_last = 1'b0;
    @(posedge clk); #1;
    char_data = 8'h32;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    char_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("TXN mid-string reset");
    run_str(5'd10, "123", 32'd123, 2'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
